// File: rtl/pcomp.sv
// Position-compare pulse generator: emits WIDTH-count windows starting at START, every STEP counts,
// for NUM pulses, flagging skipped windows and wrong-direction motion on err_o.
module pcomp (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [31:0] posn_i,
    input  logic [31:0] START,
    input  logic [31:0] STEP,
    input  logic [31:0] WIDTH,
    input  logic [31:0] NUM,
    input  logic        RELATIVE,
    input  logic        DIR,
    input  logic [31:0] FLTR_DELTAT,
    input  logic [15:0] FLTR_THOLD,
    output logic        act_o,
    output logic [31:0] err_o,
    output logic        pulse_o
);

    typedef enum logic [1:0] {StIdle, StWaitPre, StRunLow, StRunHigh} state_e;

    state_e      state_q, state_d;
    logic        en_q;
    logic [31:0] edge_q, edge_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] fltr_cnt_q, fltr_cnt_d;
    logic [31:0] fltr_ref_q, fltr_ref_d;

    logic        arm;
    logic        active;
    logic [31:0] edge_end;
    logic        past_start;
    logic        past_end;
    logic        skip;
    logic        window_done;
    logic        num_done;
    logic        fltr_en;
    logic        fltr_tick;
    logic [31:0] delta;
    logic [31:0] thold_ext;
    logic        dir_bad;
    logic        dir_err;

    // Direction-aware "a has reached or gone beyond b".
    function automatic logic past(input logic [31:0] a, input logic [31:0] b, input logic dir);
        return dir ? ($signed(a) <= $signed(b)) : ($signed(a) >= $signed(b));
    endfunction

    always_comb begin
        arm         = (state_q == StIdle) && enable_i && !en_q;
        active      = (state_q != StIdle) && enable_i;
        edge_end    = DIR ? (edge_q - WIDTH) : (edge_q + WIDTH);
        past_start  = past(posn_i, edge_q, DIR);
        past_end    = past(posn_i, edge_end, DIR);
        num_done    = (NUM != 32'd0) && (count_q + 32'd1 == NUM);

        fltr_en     = active && (FLTR_DELTAT != 32'd0);
        fltr_tick   = fltr_en && (fltr_cnt_q + 32'd1 >= FLTR_DELTAT);
        delta       = posn_i - fltr_ref_q;
        thold_ext   = {16'd0, FLTR_THOLD};
        dir_bad     = DIR ? ($signed(delta) > $signed(thold_ext))
                          : ($signed(delta) < -$signed(thold_ext));
        dir_err     = fltr_tick && dir_bad;

        // Start and end both reached in one low-pulse sample counts as a skip.
        skip        = enable_i && (state_q == StRunLow) && past_end;
        window_done = enable_i && (state_q == StRunHigh) && past_end && !dir_err;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            edge_q     <= '0;
            count_q    <= '0;
            err_q      <= '0;
            fltr_cnt_q <= '0;
            fltr_ref_q <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= enable_i;
            edge_q     <= edge_d;
            count_q    <= count_d;
            err_q      <= err_d;
            fltr_cnt_q <= fltr_cnt_d;
            fltr_ref_q <= fltr_ref_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) state_d = StWaitPre;
                end
                StWaitPre: begin
                    if (dir_err) state_d = StIdle;
                    else if (!past_start) state_d = StRunLow;
                end
                StRunLow: begin
                    if (dir_err || skip) state_d = StIdle;
                    else if (past_start) state_d = StRunHigh;
                end
                StRunHigh: begin
                    if (dir_err) state_d = StIdle;
                    else if (past_end) state_d = num_done ? StIdle : StRunLow;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        edge_d     = edge_q;
        count_d    = count_q;
        err_d      = err_q;
        fltr_cnt_d = fltr_cnt_q;
        fltr_ref_d = fltr_ref_q;
        if (arm) begin
            edge_d     = (RELATIVE ? posn_i : 32'd0) + START;
            count_d    = '0;
            err_d      = '0;
            fltr_cnt_d = '0;
            fltr_ref_d = posn_i;
        end else if (active) begin
            if (fltr_en) begin
                fltr_cnt_d = fltr_tick ? 32'd0 : fltr_cnt_q + 32'd1;
                if (fltr_tick) fltr_ref_d = posn_i;
            end
            if (skip) err_d[0] = 1'b1;
            if (dir_err) err_d[1] = 1'b1;
            if (window_done) begin
                count_d = count_q + 32'd1;
                edge_d  = DIR ? (edge_q - STEP) : (edge_q + STEP);
            end
        end
    end

    // Outputs decode straight from registered state, so they carry one clock of latency.
    always_comb begin
        act_o   = (state_q != StIdle);
        pulse_o = (state_q == StRunHigh);
        err_o   = {30'd0, err_q};
    end

endmodule

// File: tb/tb_pcomp.sv
// Directed bench for pcomp: window-offset reference model checked every clock, plus literal pins.
module tb_pcomp;

    logic        clk;
    logic        reset_i;
    logic        en;
    int          posn;
    int          start_v;
    int unsigned step_v;
    int unsigned width_v;
    int unsigned num_v;
    logic        rel_v;
    logic        dir_v;
    int unsigned deltat_v;
    logic [15:0] thold_v;
    logic        act_o;
    logic [31:0] err_o;
    logic        pulse_o;

    pcomp dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .enable_i   (en),
        .posn_i     (posn),
        .START      (start_v),
        .STEP       (step_v),
        .WIDTH      (width_v),
        .NUM        (num_v),
        .RELATIVE   (rel_v),
        .DIR        (dir_v),
        .FLTR_DELTAT(deltat_v),
        .FLTR_THOLD (thold_v),
        .act_o      (act_o),
        .err_o      (err_o),
        .pulse_o    (pulse_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 waiting to be before the window, 2 running.
    int       m_mode;
    bit       m_pulse;
    bit [1:0] m_err;
    int       m_edge;
    int       m_done;
    int       m_tcnt;
    int       m_ref;
    bit       m_en_prev;

    int rises;
    int hi_cycles;
    int first_posn;
    bit prev_pulse;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pulse = 0; m_err = 0; m_edge = 0; m_done = 0;
        m_tcnt = 0; m_ref = 0; m_en_prev = 0;
    endtask

    task automatic model_step();
        longint o, mot;
        bit skip, ferr, fin;
        int sgn;
        sgn = dir_v ? -1 : 1;
        if (!en) begin
            m_mode = 0;
            m_pulse = 0;
        end else if (m_mode == 0) begin
            if (!m_en_prev) begin
                m_mode = 1; m_pulse = 0; m_err = 0; m_done = 0; m_tcnt = 0;
                m_edge = (rel_v ? posn : 0) + start_v;
                m_ref = posn;
            end
        end else begin
            skip = 0; ferr = 0; fin = 0;
            if (deltat_v != 0) begin
                m_tcnt++;
                if (m_tcnt == int'(deltat_v)) begin
                    m_tcnt = 0;
                    mot = sgn * (longint'(posn) - longint'(m_ref));
                    m_ref = posn;
                    ferr = (mot < -longint'(thold_v));
                end
            end
            // Offset of the position into the current window, measured along the motion direction.
            o = sgn * (longint'(posn) - longint'(m_edge));
            if (m_mode == 1) begin
                if (o < 0) m_mode = 2;
            end else if (!m_pulse) begin
                if (o >= longint'(width_v)) skip = 1;
                else if (o >= 0) m_pulse = 1;
            end else if (o >= longint'(width_v)) begin
                m_pulse = 0;
                m_done++;
                m_edge = dir_v ? m_edge - int'(step_v) : m_edge + int'(step_v);
                if (num_v != 0 && m_done == int'(num_v)) fin = 1;
            end
            if (skip) m_err[0] = 1;
            if (ferr) m_err[1] = 1;
            if (skip || ferr || fin) begin
                m_mode = 0;
                m_pulse = 0;
            end
        end
        m_en_prev = en;
    endtask

    task automatic compare();
        check("act", {31'd0, act_o}, {31'd0, m_mode != 0});
        check("pulse", {31'd0, pulse_o}, {31'd0, m_pulse});
        check("err", err_o, {30'd0, m_err});
        if (pulse_o === 1'b1) hi_cycles++;
        if (pulse_o === 1'b1 && !prev_pulse) begin
            rises++;
            if (rises == 1) first_posn = posn;
        end
        prev_pulse = (pulse_o === 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic clear_stats();
        rises = 0; hi_cycles = 0; first_posn = 0;
    endtask

    task automatic setup(input int s, input int unsigned st, input int unsigned w,
                         input int unsigned n, input logic r, input logic d,
                         input int unsigned dt, input logic [15:0] th);
        start_v = s; step_v = st; width_v = w; num_v = n;
        rel_v = r; dir_v = d; deltat_v = dt; thold_v = th;
    endtask

    int fall_idx;

    initial begin
        prev_pulse = 0;
        clear_stats();
        model_reset();
        en = 0;
        posn = 0;
        setup(100, 50, 10, 3, 1'b0, 1'b0, 0, 16'd0);
        reset_i = 1'b1;
        #2 reset_i = 1'b0;
        #4;
        check("reset_act", {31'd0, act_o}, 32'd0);
        check("reset_pulse", {31'd0, pulse_o}, 32'd0);
        check("reset_err", err_o, 32'd0);
        #6 reset_i = 1'b1;

        // Basic forward run
        tick(); tick();
        en = 1; tick();
        clear_stats();
        for (int p = 0; p <= 300; p++) begin
            posn = p;
            tick();
        end
        check("fwd_rises", rises, 3);
        check("fwd_hi_cycles", hi_cycles, 30);
        check("fwd_first_posn", first_posn, 100);
        check("fwd_act_end", {31'd0, act_o}, 32'd0);
        check("fwd_err_end", err_o, 32'd0);
        en = 0; tick();

        // Relative reverse run
        setup(-20, 10, 5, 2, 1'b1, 1'b1, 0, 16'd0);
        posn = 1000; tick();
        en = 1; tick();
        clear_stats();
        for (int p = 1000; p >= 940; p--) begin
            posn = p;
            tick();
        end
        check("rev_rises", rises, 2);
        check("rev_hi_cycles", hi_cycles, 10);
        check("rev_first_posn", first_posn, 980);
        check("rev_act_end", {31'd0, act_o}, 32'd0);
        en = 0; tick();

        // Skip: position jumps across the whole window
        setup(100, 50, 10, 3, 1'b0, 1'b0, 0, 16'd0);
        posn = 80; en = 1; tick();
        clear_stats();
        for (int p = 81; p <= 90; p++) begin
            posn = p;
            tick();
        end
        posn = 120; tick();
        check("skip_err", err_o, 32'd1);
        check("skip_act", {31'd0, act_o}, 32'd0);
        check("skip_rises", rises, 0);
        posn = 121; tick();
        en = 0; tick();
        tick();

        // Direction filter: slow backward creep is tolerated, fast backward motion trips it
        setup(1000, 50, 10, 3, 1'b0, 1'b0, 10, 16'd5);
        posn = 500; en = 1; tick();
        for (int i = 1; i <= 30; i++) begin
            posn = 500 - i / 3;
            tick();
        end
        check("fltr_slow_act", {31'd0, act_o}, 32'd1);
        check("fltr_slow_err", err_o, 32'd0);
        fall_idx = -1;
        for (int i = 1; i <= 15; i++) begin
            posn = 490 - i;
            tick();
            if (fall_idx < 0 && act_o === 1'b0) fall_idx = i;
        end
        check("fltr_fall_idx", fall_idx, 10);
        check("fltr_err", err_o, 32'd2);
        en = 0; tick();

        // Abort during the second pulse, then re-arm
        setup(100, 50, 10, 3, 1'b0, 1'b0, 0, 16'd0);
        posn = 0; en = 1; tick();
        check("abort_err_cleared", err_o, 32'd0);
        for (int p = 0; p <= 154; p++) begin
            posn = p;
            tick();
        end
        check("abort_pulse_before", {31'd0, pulse_o}, 32'd1);
        en = 0; posn = 155; tick();
        check("abort_pulse", {31'd0, pulse_o}, 32'd0);
        check("abort_act", {31'd0, act_o}, 32'd0);
        posn = 0; en = 1; tick();
        clear_stats();
        for (int p = 0; p <= 300; p++) begin
            posn = p;
            tick();
        end
        check("rearm_rises", rises, 3);
        check("rearm_act_end", {31'd0, act_o}, 32'd0);
        en = 0; tick();

        // Asynchronous reset in the middle of a pulse
        posn = 0; en = 1; tick();
        for (int p = 0; p <= 102; p++) begin
            posn = p;
            tick();
        end
        #2 reset_i = 1'b0;
        #1;
        check("async_act", {31'd0, act_o}, 32'd0);
        check("async_pulse", {31'd0, pulse_o}, 32'd0);
        check("async_err", err_o, 32'd0);
        model_reset();
        en = 0;
        #3 reset_i = 1'b1;
        prev_pulse = 0;
        tick();

        // Unlimited pulses with NUM=0 until enable falls
        setup(100, 20, 5, 0, 1'b0, 1'b0, 0, 16'd0);
        posn = 0; en = 1; tick();
        clear_stats();
        for (int p = 0; p <= 400; p++) begin
            posn = p;
            tick();
        end
        check("unlim_rises", rises, 16);
        check("unlim_act", {31'd0, act_o}, 32'd1);
        en = 0; posn = 401; tick();
        check("unlim_pulse_off", {31'd0, pulse_o}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
